// File: rtl/ram_dma_if.sv
// RAM port bundle between the DMA engine (master) and the RAM (slave).
// mem_read is combinational from mem_addr while mem_ld is high.
interface ram_dma_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 20
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_str;
   logic              mem_ld;
   logic [DATA_W-1:0] mem_read;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_str,
      output mem_ld,
      input  mem_read
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_str,
      input  mem_ld,
      output mem_read
   );
endinterface

// File: rtl/ram_dma.sv
// Word-at-a-time RAM-to-RAM copy engine with optional pattern fill.
// Define RAM_DMA_FILL_EN to enable fill mode (fill/pattern ignored otherwise).
module ram_dma #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W:0]   len,
   input  logic              fill,
   input  logic [DATA_W-1:0] pattern,
   output logic              busy,
   output logic              done,
   ram_dma_if.master         bus
);

`ifdef RAM_DMA_FILL_EN
   localparam logic FillEn = 1'b1;
`else
   localparam logic FillEn = 1'b0;
`endif

   localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] One    = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic              fill_q, fill_d;

   logic [ADDR_W:0]   len_c;
   logic              fill_c;

   assign len_c  = (len > MaxLen) ? MaxLen : len;
   assign fill_c = fill & FillEn;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         pat_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         pat_q   <= pat_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      pat_d   = pat_q;
      fill_d  = fill_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len_c == '0) begin
                  state_d = DONE;
               end else begin
                  src_d   = src;
                  dst_d   = dst;
                  cnt_d   = len_c;
                  pat_d   = pattern;
                  fill_d  = fill_c;
                  state_d = fill_c ? WR : RD;
               end
            end
         end
         RD: begin
            buf_d   = bus.mem_read;
            state_d = WR;
         end
         WR: begin
            src_d = src_q + 1'b1;
            dst_d = dst_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == One) begin
               state_d = DONE;
            end else begin
               state_d = fill_q ? WR : RD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Store is gated by rst so a reset edge never commits a write.
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_str   = 1'b0;
      bus.mem_ld    = 1'b0;
      unique case (state_q)
         RD: begin
            busy         = 1'b1;
            bus.mem_addr = src_q;
            bus.mem_ld   = 1'b1;
         end
         WR: begin
            busy          = 1'b1;
            bus.mem_addr  = dst_q;
            bus.mem_wdata = fill_q ? pat_q : buf_q;
            bus.mem_str   = ~rst;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 The module SHALL provide parameter ADDR_W, default 10, RAM address width (1024 words).
REQ-002 The module SHALL provide parameter DATA_W, default 20, RAM word width.
REQ-003 The module SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL provide port start  input  1  request pulse; sampled only in IDLE.
REQ-006 The module SHALL provide port src  input  ADDR_W  first source word address.
REQ-007 The module SHALL provide port dst  input  ADDR_W  first destination word address.
REQ-008 The module SHALL provide port len  input  ADDR_W+1  word count, 0..1024.
REQ-009 The module SHALL provide port fill  input  1  fill-mode select (see Configuration).
REQ-010 The module SHALL provide port pattern  input  DATA_W  fill word.
REQ-011 The module SHALL provide port busy  output  1  high in RD and WR states.
REQ-012 The module SHALL provide port done  output  1  one-cycle completion pulse.
REQ-013 The module SHALL provide port mem_addr  output  ADDR_W  RAM address.
REQ-014 The module SHALL provide port mem_wdata  output  DATA_W  RAM write data.
REQ-015 The module SHALL provide port mem_str  output  1  RAM store enable.
REQ-016 The module SHALL provide port mem_ld  output  1  RAM load enable.
REQ-017 The module SHALL provide port mem_read  input  DATA_W  RAM read data, combinational from mem_addr while mem_ld is high.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR and DONE; all outputs SHALL be decoded from state and registers only.
REQ-019 In IDLE, a clock edge with start=1 and len>0 SHALL latch src, dst, pattern and the count, then enter RD (or WR when fill mode is active).
REQ-020 In IDLE, a clock edge with start=1 and len=0 SHALL enter DONE directly, with no RAM access.
REQ-021 A len value above 1024 SHALL be clamped to 1024.
REQ-022 In RD, the module SHALL drive mem_addr=src_ptr, mem_ld=1, mem_str=0; the next edge SHALL capture mem_read into buf and enter WR.
REQ-023 In WR, the module SHALL drive mem_addr=dst_ptr, mem_wdata=buf (pattern in fill mode), mem_str=1, mem_ld=0.
REQ-024 At the end of each WR cycle, src_ptr and dst_ptr SHALL increment, count SHALL decrement, and the FSM SHALL enter DONE when count was 1, else RD (else WR in fill mode).
REQ-025 Pointers SHALL wrap modulo 2^ADDR_W (1023 -> 0) with no error.
REQ-026 Copy SHALL proceed strictly ascending, one word at a time; an overlap with dst>src SHALL propagate words forward, and this is the defined behaviour.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-028 start SHALL be ignored in RD, WR and DONE.
REQ-029 Latency SHALL be 2N busy cycles in copy mode and N in fill mode, with done in the following cycle.
REQ-030 In IDLE and DONE, mem_addr, mem_wdata, mem_str and mem_ld SHALL all be 0.

Reset
REQ-031 A clock edge with rst=1 SHALL force state IDLE and clear src_ptr, dst_ptr, count and buf to 0; busy and done SHALL be 0 after it.
REQ-032 mem_str SHALL be combinationally gated by !rst so that no RAM write occurs on the edge where reset is sampled, including mid-transfer.
REQ-033 rst SHALL take priority over start on the same edge.

Configuration
REQ-034 With RAM_DMA_FILL_EN defined, fill=1 at start acceptance SHALL select fill mode: RD is skipped and pattern is written to N consecutive dst words.
REQ-035 Without RAM_DMA_FILL_EN, the fill and pattern ports SHALL remain present but be ignored, and every transfer SHALL be a copy.

Verification
REQ-036 The bench SHALL preload mem[5..7]=1,2,3, then issue start src=5 dst=100 len=3 -> mem[100..102]=1,2,3; busy high for 6 cycles; done pulses once in cycle 7.
REQ-037 The bench SHALL issue start len=0 -> done in the next cycle; mem_str and mem_ld never asserted.
REQ-038 The bench SHALL issue src=1022 dst=10 len=4 -> reads 1022,1023,0,1; writes 10..13 in that order.
REQ-039 The bench SHALL assert rst during the WR cycle of word 2 of a len=5 copy -> mem_str is 0 on that edge; only word 1 is written; IDLE follows.
REQ-040 The bench SHALL, with RAM_DMA_FILL_EN defined, issue fill=1 pattern=20'hABCDE dst=0 len=4 -> mem[0..3]=20'hABCDE; busy high 4 cycles; mem_ld never high.
REQ-041 The bench SHALL pulse start again while busy -> it is ignored; exactly one done pulse results.
